// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the writeback record.
package cpu_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 1 << REG_AW;

  // One register-file write: {rd, data}, 37 bits.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_rec_t;

endpackage

// File: rtl/reg_wb_scheduler_if.sv
// Issue / writeback / long-unit / register-file bundle of reg_wb_scheduler.
//   master : CPU side (drives issue, pipeline writeback, long-unit results)
//   slave  : scheduler (drives stall, lu_ready, write port, busy, err)
interface reg_wb_scheduler_if;
  import cpu_pkg::*;

  logic              issue_valid;
  logic [REG_AW-1:0] issue_rs1;
  logic              issue_rs1_used;
  logic [REG_AW-1:0] issue_rs2;
  logic              issue_rs2_used;
  logic [REG_AW-1:0] issue_rd;
  logic              issue_long;
  logic              issue_stall;

  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              lu_valid;
  logic              lu_ready;
  logic [REG_AW-1:0] lu_rd;
  logic [XLEN-1:0]   lu_data;

  logic              rf_wen;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  logic [NREGS-1:0]  busy;
  logic              err;

  modport master (
    output issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
           issue_rd, issue_long, wb_valid, wb_rd, wb_data,
           lu_valid, lu_rd, lu_data,
    input  issue_stall, lu_ready, rf_wen, rf_waddr, rf_wdata, busy, err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
           issue_rd, issue_long, wb_valid, wb_rd, wb_data,
           lu_valid, lu_rd, lu_data,
    output issue_stall, lu_ready, rf_wen, rf_waddr, rf_wdata, busy, err
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback records.
//   clk, reset   : clock, async active-high reset (empties the FIFO)
//   i_push       : write i_push_rec (ignored when full)
//   i_pop        : drop the head entry (ignored when empty)
//   o_full_c     : no free slot (combinational from pointers)
//   o_empty_c    : no valid entry (combinational from pointers)
//   o_head_c     : oldest entry, valid when !o_empty_c
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    i_push,
  input  wb_rec_t i_push_rec,
  input  logic    i_pop,
  output logic    o_full_c,
  output logic    o_empty_c,
  output wb_rec_t o_head_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  wb_rec_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign o_empty_c = (r_wr_ptr == r_rd_ptr);
  assign o_full_c  = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
  assign o_head_c  = r_mem[r_rd_ptr[IDX_W-1:0]];

  assign w_do_push = i_push & ~o_full_c;
  assign w_do_pop  = i_pop  & ~o_empty_c;

  // Pointer update; wrap is implicit because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_rec;
  end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Register-file write-port scheduler and long-latency scoreboard.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of reg_wb_scheduler_if
//                issue_*  -> issue_stall (RAW/WAW/outstanding-limit hold)
//                wb_*     : pipeline writeback, always owns the port
//                lu_*     : long-unit results, buffered in wb_fifo
//                rf_*     : single register-file write port
//                busy     : pending long-latency destinations
//                err      : sticky protocol error
module reg_wb_scheduler
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  reg_wb_scheduler_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_err;
  logic             w_err_nxt;

  logic             w_full;
  logic             w_empty;
  wb_rec_t          w_head;
  wb_rec_t          w_push_rec;
  logic             w_lu_acc;
  logic             w_wb_take;
  logic             w_pop;
  logic             w_long_go;
  logic             w_stall;
  logic             w_cnt_max;

  // Hazard detection on the pre-edge scoreboard.
  assign w_cnt_max = (r_cnt == CNT_W'(MAX_OUT));
  assign w_stall   = bus.issue_valid &
                     ((bus.issue_rs1_used & r_busy[bus.issue_rs1]) |
                      (bus.issue_rs2_used & r_busy[bus.issue_rs2]) |
                      r_busy[bus.issue_rd] |
                      (bus.issue_long & w_cnt_max));
  assign w_long_go = bus.issue_valid & ~w_stall & bus.issue_long;

  // Port arbitration: pipeline first; an rd==0 head is dropped without the port.
  assign w_lu_acc   = bus.lu_valid & ~w_full;
  assign w_wb_take  = bus.wb_valid & (bus.wb_rd != '0);
  assign w_pop      = ~w_empty & (~w_wb_take | (w_head.rd == '0));
  assign w_push_rec = '{rd: bus.lu_rd, data: bus.lu_data};

  assign bus.lu_ready    = ~w_full;
  assign bus.issue_stall = w_stall;
  assign bus.busy        = r_busy;
  assign bus.err         = r_err;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_lu_acc),
    .i_push_rec (w_push_rec),
    .i_pop      (w_pop),
    .o_full_c   (w_full),
    .o_empty_c  (w_empty),
    .o_head_c   (w_head)
  );

  // Write-port mux.
  always_comb begin
    bus.rf_wen   = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (w_wb_take) begin
      bus.rf_wen   = 1'b1;
      bus.rf_waddr = bus.wb_rd;
      bus.rf_wdata = bus.wb_data;
    end else if (w_pop && (w_head.rd != '0)) begin
      bus.rf_wen   = 1'b1;
      bus.rf_waddr = w_head.rd;
      bus.rf_wdata = w_head.data;
    end
  end

  // Scoreboard, outstanding count and error next state; set wins over clear.
  always_comb begin
    w_busy_nxt = r_busy;
    w_cnt_nxt  = r_cnt;
    w_err_nxt  = r_err;
    if (w_pop) w_busy_nxt[w_head.rd] = 1'b0;
    if (w_long_go && (bus.issue_rd != '0)) w_busy_nxt[bus.issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    case ({w_long_go, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
    if (bus.wb_valid && r_busy[bus.wb_rd]) w_err_nxt = 1'b1;
    if (w_lu_acc && (bus.lu_rd != '0) && !r_busy[bus.lu_rd]) w_err_nxt = 1'b1;
    if (w_lu_acc && (r_cnt == '0)) w_err_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
      r_err  <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Self-checking bench for reg_wb_scheduler: directed scenarios plus a
// write-order scoreboard for long-unit results.
module tb_reg_wb_scheduler;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;
  logic [36:0] exp_q [$];

  reg_wb_scheduler_if bus ();

  reg_wb_scheduler #(.DEPTH(2), .MAX_OUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.issue_valid    = 1'b0;
    bus.issue_rs1      = 5'd0;
    bus.issue_rs1_used = 1'b0;
    bus.issue_rs2      = 5'd0;
    bus.issue_rs2_used = 1'b0;
    bus.issue_rd       = 5'd0;
    bus.issue_long     = 1'b0;
    bus.wb_valid       = 1'b0;
    bus.wb_rd          = 5'd0;
    bus.wb_data        = 32'd0;
    bus.lu_valid       = 1'b0;
    bus.lu_rd          = 5'd0;
    bus.lu_data        = 32'd0;
  endtask

  task automatic issue(input logic lng, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd);
    bus.issue_valid    = 1'b1;
    bus.issue_long     = lng;
    bus.issue_rs1      = rs1;
    bus.issue_rs1_used = u1;
    bus.issue_rs2      = rs2;
    bus.issue_rs2_used = u2;
    bus.issue_rd       = rd;
  endtask

  task automatic lu(input logic [4:0] rd, input logic [31:0] data);
    bus.lu_valid = 1'b1;
    bus.lu_rd    = rd;
    bus.lu_data  = data;
  endtask

  // Write-port scoreboard: pipeline writes are checked in place, every other
  // write must be the oldest long-unit result accepted in an earlier cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus.wb_valid && bus.wb_rd != 5'd0) begin
        chk("wb_wen",  64'(bus.rf_wen),   64'(1'b1));
        chk("wb_addr", 64'(bus.rf_waddr), 64'(bus.wb_rd));
        chk("wb_data", 64'(bus.rf_wdata), 64'(bus.wb_data));
      end else if (bus.rf_wen) begin
        if (exp_q.size() == 0) begin
          chk("lu_spurious_wen", 64'(bus.rf_wen), 64'(1'b0));
        end else begin
          chk("lu_wr_order", 64'({bus.rf_waddr, bus.rf_wdata}), 64'(exp_q.pop_front()));
        end
      end
      if (bus.lu_valid && bus.lu_ready && bus.lu_rd != 5'd0)
        exp_q.push_back({bus.lu_rd, bus.lu_data});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset / idle state.
    smp();
    chk("rst_busy",     64'(bus.busy),        64'(0));
    chk("rst_lu_ready", 64'(bus.lu_ready),    64'(1'b1));
    chk("rst_rf_wen",   64'(bus.rf_wen),      64'(1'b0));
    chk("rst_stall",    64'(bus.issue_stall), 64'(1'b0));
    chk("rst_err",      64'(bus.err),         64'(1'b0));
    nxt();

    // RAW on a pending long load to x5.
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5);
    smp(); chk("raw_long_go", 64'(bus.issue_stall), 64'(1'b0)); nxt();
    issue(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
    smp(); chk("raw_busy5", 64'(bus.busy), 64'(32'h0000_0020)); nxt();
    for (int i = 0; i < 3; i++) begin
      smp(); chk("raw_stall_hold", 64'(bus.issue_stall), 64'(1'b1)); nxt();
    end
    lu(5'd5, 32'hDEAD_BEEF);
    smp();
    chk("raw_acc_ready", 64'(bus.lu_ready),    64'(1'b1));
    chk("raw_acc_stall", 64'(bus.issue_stall), 64'(1'b1));
    chk("raw_no_bypass", 64'(bus.rf_wen),      64'(1'b0));
    nxt();
    bus.lu_valid = 1'b0;
    smp();
    chk("raw_wr_addr", 64'(bus.rf_waddr),    64'(5'd5));
    chk("raw_wr_data", 64'(bus.rf_wdata),    64'(32'hDEAD_BEEF));
    chk("raw_wr_stall", 64'(bus.issue_stall), 64'(1'b1));
    nxt();
    smp();
    chk("raw_release", 64'(bus.issue_stall), 64'(1'b0));
    chk("raw_busy_clr", 64'(bus.busy),       64'(0));
    nxt();
    idle();

    // Pipeline writeback holds off a buffered x7 for three cycles.
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7);
    smp(); nxt();
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd3;
      bus.wb_data  = 32'h30 + 32'(i);
      if (i == 0) lu(5'd7, 32'h0707_0707);
      else        bus.lu_valid = 1'b0;
      smp(); chk("wbpri_addr3", 64'(bus.rf_waddr), 64'(5'd3)); nxt();
    end
    bus.wb_valid = 1'b0;
    smp();
    chk("wbpri_wen7",  64'(bus.rf_wen),   64'(1'b1));
    chk("wbpri_addr7", 64'(bus.rf_waddr), 64'(5'd7));
    chk("wbpri_busy7_held", 64'(bus.busy[7]), 64'(1'b1));
    nxt();
    smp();
    chk("wbpri_busy7_clr", 64'(bus.busy[7]), 64'(1'b0));
    chk("wbpri_idle_wen",  64'(bus.rf_wen),  64'(1'b0));
    nxt();

    // FIFO full back-pressure with the pipeline owning the port.
    for (int i = 10; i < 13; i++) begin
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i));
      smp(); chk("bp_issue", 64'(bus.issue_stall), 64'(1'b0)); nxt();
    end
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h100;
    lu(5'd10, 32'hAAAA_0010);
    smp(); chk("bp_rdy_a", 64'(bus.lu_ready), 64'(1'b1)); nxt();
    lu(5'd11, 32'hBBBB_0011);
    smp(); chk("bp_rdy_b", 64'(bus.lu_ready), 64'(1'b1)); nxt();
    lu(5'd12, 32'hCCCC_0012);
    smp(); chk("bp_full", 64'(bus.lu_ready), 64'(1'b0)); nxt();
    bus.wb_valid = 1'b0;
    smp();
    chk("bp_full_on_pop", 64'(bus.lu_ready), 64'(1'b0));
    chk("bp_pop10",       64'(bus.rf_waddr), 64'(5'd10));
    nxt();
    smp();
    chk("bp_rdy_after", 64'(bus.lu_ready), 64'(1'b1));
    chk("bp_pop11",     64'(bus.rf_waddr), 64'(5'd11));
    nxt();
    bus.lu_valid = 1'b0;
    smp(); chk("bp_pop12", 64'(bus.rf_waddr), 64'(5'd12)); nxt();
    smp(); chk("bp_busy_clr", 64'(bus.busy), 64'(0)); nxt();

    // Outstanding limit.
    for (int i = 1; i <= 4; i++) begin
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i));
      smp(); chk("lim_issue", 64'(bus.issue_stall), 64'(1'b0)); nxt();
    end
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8);
    smp(); chk("lim_fifth_stall", 64'(bus.issue_stall), 64'(1'b1)); nxt();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9);
    smp(); chk("lim_short_go", 64'(bus.issue_stall), 64'(1'b0)); nxt();
    idle();
    for (int i = 1; i <= 4; i++) begin
      lu(5'(i), 32'h1111 * 32'(i));
      smp(); chk("lim_ret_rdy", 64'(bus.lu_ready), 64'(1'b1)); nxt();
    end
    bus.lu_valid = 1'b0;
    smp(); nxt();
    smp(); chk("lim_busy_clr", 64'(bus.busy), 64'(0)); nxt();

    // wb_valid to x0 leaves the port free for the FIFO head.
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13);
    smp(); nxt();
    idle();
    lu(5'd13, 32'h1313_1313);
    smp(); nxt();
    bus.lu_valid = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF;
    smp();
    chk("x0wb_wen",  64'(bus.rf_wen),   64'(1'b1));
    chk("x0wb_addr", 64'(bus.rf_waddr), 64'(5'd13));
    nxt();
    idle();

    // Long op to x0: counted, no busy bit, return writes nothing.
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    smp(); chk("x0_issue", 64'(bus.issue_stall), 64'(1'b0)); nxt();
    idle();
    lu(5'd0, 32'h0000_0ABC);
    smp();
    chk("x0_busy", 64'(bus.busy), 64'(0));
    chk("x0_rdy",  64'(bus.lu_ready), 64'(1'b1));
    nxt();
    bus.lu_valid = 1'b0;
    smp();
    chk("x0_no_wen", 64'(bus.rf_wen), 64'(1'b0));
    chk("x0_err",    64'(bus.err),    64'(1'b0));
    nxt();
    // Count is back to 0, so a further return is a protocol error.
    lu(5'd0, 32'h0000_0DEF);
    smp(); chk("cnt0_err_pre", 64'(bus.err), 64'(1'b0)); nxt();
    bus.lu_valid = 1'b0;
    smp(); chk("cnt0_err", 64'(bus.err), 64'(1'b1)); nxt();

    // Reset clears err and scoreboard mid-operation.
    reset = 1'b1;
    smp();
    chk("rst2_err",  64'(bus.err),  64'(1'b0));
    chk("rst2_busy", 64'(bus.busy), 64'(0));
    nxt();
    reset = 1'b0;

    // Pipeline writeback to a busy register sets sticky err.
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2);
    smp(); nxt();
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h2222;
    smp(); chk("waw_err_pre", 64'(bus.err), 64'(1'b0)); nxt();
    bus.wb_valid = 1'b0;
    smp(); chk("waw_err_set", 64'(bus.err), 64'(1'b1)); nxt();
    smp(); nxt();
    smp(); chk("waw_err_sticky", 64'(bus.err), 64'(1'b1)); nxt();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_wb_scheduler.md
Name: reg_wb_scheduler

Overview:
- Scoreboard and write-port scheduler for the 32x32 register file (single write port, x0 hard-wired to zero).
- Shares the one write port between the in-order pipeline writeback and a long-latency unit (load/divide) that returns results out of band.
- Tracks registers with pending long-latency writes and stalls issue on RAW/WAW hazards.
- Buffers long-latency returns in a small FIFO when the port is taken.

Parameters:
- DEPTH, 2, return FIFO entries (power of two, >=2).
- MAX_OUT, 4, maximum outstanding long-latency ops.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- issue_valid  in  1  instruction at issue stage
- issue_rs1  in  5  source 1 address
- issue_rs1_used  in  1  rs1 is read
- issue_rs2  in  5  source 2 address
- issue_rs2_used  in  1  rs2 is read
- issue_rd  in  5  destination address
- issue_long  in  1  result will come from the long-latency unit
- issue_stall  out  1  hold issue this cycle
- wb_valid  in  1  pipeline writeback (cannot be stalled)
- wb_rd  in  5  writeback address
- wb_data  in  32  writeback data
- lu_valid  in  1  long unit result valid
- lu_ready  out  1  result accepted
- lu_rd  in  5  long unit destination
- lu_data  in  32  long unit data
- rf_wen  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data
- busy  out  32  scoreboard vector, bit 0 always 0
- err  out  1  sticky protocol error

Behaviour:
- Reset (async):
  - busy=0, FIFO empty, outstanding count=0, err=0.
  - Consequently lu_ready=1, rf_wen=0, issue_stall=0.
  - Reset mid-operation discards buffered results and pending busy bits.
- Handshake: LU transfer occurs when lu_valid & lu_ready; lu_ready = !fifo_full (combinational, independent of lu_valid).
- Accepted LU result:
  - Pushed into the FIFO on the same clk edge.
  - Earliest write is the next cycle, so latency from accept to rf_wen is >=1 cycle.
  - No bypass from lu_* to rf_*.
- Write port (combinational):
  - If wb_valid & wb_rd!=0: drive wb_rd/wb_data with rf_wen=1. The pipeline always wins.
  - Else if FIFO non-empty and head rd!=0: drive head with rf_wen=1 and pop.
  - Else rf_wen=0.
  - A head with rd==0 is popped with no write.
  - wb_valid with wb_rd==0 does not occupy the port; the FIFO may drain that cycle.
- Simultaneous push and pop: the FIFO handles both on the same edge, including when full (pop frees the slot only next cycle; lu_ready uses the pre-edge count).
- Scoreboard:
  - A long issue (issue_valid & !issue_stall & issue_long) sets busy[issue_rd] when rd!=0 and increments the outstanding count, including for rd==0.
  - A FIFO pop clears busy[head rd] and decrements the count.
  - A simultaneous increment and decrement leaves the count unchanged.
  - Set and clear of the same register in one cycle cannot occur: the WAW stall guarantees it. If it does occur, set wins.
- issue_stall = issue_valid & ( (rs1_used & busy[rs1]) | (rs2_used & busy[rs2]) | busy[rd] | (issue_long & count==MAX_OUT) ).
  - Stall is evaluated on the pre-edge busy value; a register being cleared this cycle still stalls (one-cycle conservative).
  - A value written this cycle reaches the reader next cycle through the register file's write-through.
- err is set (sticky until reset) on any of:
  - wb_valid with busy[wb_rd]
  - LU accept with lu_rd!=0 and !busy[lu_rd]
  - LU accept when count==0
- Width rules:
  - Count width is clog2(MAX_OUT+1).
  - FIFO pointers are one bit wider than the index; wrap is modulo DEPTH.

Decomposition:
- Shared package cpu_pkg: REG_AW=5, XLEN=32, and a typedef for the {rd, data} writeback record (37 bits).
- One sub-module: wb_fifo, a synchronous FIFO of writeback records with push/pop/full/empty/head, async reset, parameter DEPTH.
- The scoreboard, stall logic, and port mux stay in the top module.

Test Plan:
- Reset then idle -> busy=0, lu_ready=1, rf_wen=0, issue_stall=0, err=0.
- Long issue rd=5 at cycle 0, then issue reading rs1=5 -> busy[5]=1 from cycle 1, stall held until lu_rd=5 returns; data 0xDEADBEEF accepted cycle N, written cycle N+1 (rf_waddr=5), stall drops at N+2.
- lu result rd=7 accepted while wb_valid rd=3 for 3 consecutive cycles -> rf writes 3,3,3, then rd=7 on the 4th cycle; busy[7] clears after that write.
- Two LU results while wb is continuously valid (DEPTH=2) -> lu_ready=0 on the third attempt; the held lu_valid transfers in the cycle after the first pop; no data lost, writes in FIFO order.
- Four long issues (rd=1..4) with no returns -> the fifth long issue stalls (count=4); a non-long issue to an unrelated rd (rd=9) proceeds.
- Long issue with rd=0, then LU return rd=0 -> no rf_wen and count returns to 0; separately, wb_valid rd=2 while busy[2]=1 -> err=1 and stays set.
